// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and requester-id width shared by alu_arbiter and alu_core
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int ID_W = 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 32-bit ALU; unknown opcodes give 0, zero flag only for SUB with equal operands
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] data,
  output logic        zero
);
  always_comb begin
    data = ctrl == OP_AND ? (a & b) :
           ctrl == OP_OR  ? (a | b) :
           ctrl == OP_ADD ? (a + b) :
           ctrl == OP_SUB ? (a - b) :
           ctrl == OP_MUL ? (a * b) : '0;
    zero = ctrl == OP_SUB && a == b;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared ALU with multi-cycle MUL.
// Define ALU_ARBITER_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  input  logic [2:0]      req0_ctrl_i,
  input  logic [31:0]     req0_data1_i,
  input  logic [31:0]     req0_data2_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [2:0]      req1_ctrl_i,
  input  logic [31:0]     req1_data1_i,
  input  logic [31:0]     req1_data2_i,
  output logic            req1_ready_o,
`ifdef ALU_ARBITER_STATS_EN
  output logic [15:0]     gnt0_cnt_o,
  output logic [15:0]     gnt1_cnt_o,
`endif
  output logic            rsp_valid_o,
  output logic [ID_W-1:0] rsp_id_o,
  output logic [31:0]     rsp_data_o,
  output logic            rsp_zero_o,
  input  logic            rsp_ready_i
);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  logic [1:0]      rst_sync;
  logic            rst_n;
  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic [ID_W-1:0] rr_ptr, gnt_id;
  logic            gnt;
  logic [2:0]      sel_ctrl, op_ctrl;
  logic [31:0]     sel_a, sel_b, op_a, op_b, alu_data;
  logic            alu_zero;
  // Assertion reaches every flop at once; release is retimed to clk_i.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    gnt = rst_n && state == IDLE && (req0_valid_i || req1_valid_i);
    gnt_id = (req0_valid_i && req1_valid_i) ? rr_ptr : ID_W'(req1_valid_i);
    req0_ready_o = gnt && !gnt_id[0];
    req1_ready_o = gnt && gnt_id[0];
    sel_ctrl = gnt_id[0] ? req1_ctrl_i : req0_ctrl_i;
    sel_a = gnt_id[0] ? req1_data1_i : req0_data1_i;
    sel_b = gnt_id[0] ? req1_data2_i : req0_data2_i;
    state_nx = state == IDLE ? (gnt ? EXEC : IDLE) :
               state == EXEC ? (cnt == '0 ? RESP : EXEC) :
               (rsp_ready_i ? IDLE : RESP);
    rsp_valid_o = state == RESP;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rr_ptr <= '0;
      op_ctrl <= '0;
      op_a <= '0;
      op_b <= '0;
      rsp_id_o <= '0;
      rsp_data_o <= '0;
      rsp_zero_o <= '0;
    end else if (gnt) begin
      rr_ptr <= ~gnt_id;
      op_ctrl <= sel_ctrl;
      op_a <= sel_a;
      op_b <= sel_b;
      rsp_id_o <= gnt_id;
      cnt <= sel_ctrl == OP_MUL ? MUL_CNT : '0;
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        rsp_data_o <= alu_data;
        rsp_zero_o <= alu_zero;
      end else cnt <= cnt - 1'b1;
    end
  alu_core u_core (
    .ctrl(op_ctrl),
    .a   (op_a),
    .b   (op_b),
    .data(alu_data),
    .zero(alu_zero)
  );
`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      gnt0_cnt_o <= '0;
      gnt1_cnt_o <= '0;
    end else begin
      gnt0_cnt_o <= (req0_ready_o && gnt0_cnt_o != 16'hFFFF) ? gnt0_cnt_o + 1'b1 : gnt0_cnt_o;
      gnt1_cnt_o <= (req1_ready_o && gnt1_cnt_o != 16'hFFFF) ? gnt1_cnt_o + 1'b1 : gnt1_cnt_o;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with MUL_LAT=4
module tb_alu_arbiter;
  import alu_pkg::*;
  logic        clk_i = 0, rst_i = 0;
  logic        req0_valid_i = 0, req1_valid_i = 0;
  logic [2:0]  req0_ctrl_i = 0, req1_ctrl_i = 0;
  logic [31:0] req0_data1_i = 0, req0_data2_i = 0, req1_data1_i = 0, req1_data2_i = 0;
  logic        req0_ready_o, req1_ready_o, rsp_valid_o, rsp_zero_o, rsp_ready_i = 0;
  logic [0:0]  rsp_id_o;
  logic [31:0] rsp_data_o;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] gnt0_cnt_o, gnt1_cnt_o;
`endif
  int n_chk = 0, n_pass = 0;
  alu_arbiter #(.MUL_LAT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ctrl_i(req0_ctrl_i),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_ctrl_i(req1_ctrl_i),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ready_o(req1_ready_o),
`ifdef ALU_ARBITER_STATS_EN
    .gnt0_cnt_o(gnt0_cnt_o), .gnt1_cnt_o(gnt1_cnt_o),
`endif
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_zero_o(rsp_zero_o), .rsp_ready_i(rsp_ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input int id, input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_valid_i = v; req0_ctrl_i = c; req0_data1_i = a; req0_data2_i = b;
    end else begin
      req1_valid_i = v; req1_ctrl_i = c; req1_data1_i = a; req1_data2_i = b;
    end
  endtask
  task automatic run_op(input int id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ed, input logic ez);
    drive(id, 1'b1, c, a, b);
    #1;
    chk("accept_ready", {30'd0, req1_ready_o, req0_ready_o}, id == 0 ? 32'd1 : 32'd2);
    step();
    drive(id, 1'b0, c, a, b);
    repeat (lat - 1) step();
    chk("rsp_early", 32'(rsp_valid_o), 32'd0);
    step();
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_data", rsp_data_o, ed);
    chk("rsp_zero", 32'(rsp_zero_o), 32'(ez));
    chk("rsp_id", 32'(rsp_id_o), 32'(id));
    rsp_ready_i = 1;
    step();
    rsp_ready_i = 0;
    #1;
    chk("rsp_drop", 32'(rsp_valid_o), 32'd0);
    chk("data_keep", rsp_data_o, ed);
  endtask
  initial begin
    repeat (3) step();
    rst_i = 1;
    repeat (3) step();
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_data", rsp_data_o, 32'd0);
    chk("rst_zero", 32'(rsp_zero_o), 32'd0);
    chk("rst_id", 32'(rsp_id_o), 32'd0);
    chk("rst_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
    run_op(0, OP_ADD, 32'd5, 32'd7, 1, 32'd12, 1'b0);
    run_op(1, OP_SUB, 32'd9, 32'd9, 1, 32'd0, 1'b1);
    run_op(1, OP_SUB, 32'd3, 32'd9, 1, 32'hFFFF_FFFA, 1'b0);
    run_op(0, OP_AND, 32'hF0, 32'h0F, 1, 32'd0, 1'b0);
    run_op(1, 3'b011, 32'd6, 32'd6, 1, 32'd0, 1'b0);
    run_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
    run_op(0, OP_MUL, 32'h1_0000, 32'h1_0000, 4, 32'd0, 1'b0);
    run_op(1, OP_MUL, 32'd7, 32'd6, 4, 32'd42, 1'b0);
    // response held while the consumer stalls, with a competing requester waiting
    drive(1, 1'b1, OP_OR, 32'hF0, 32'h0F);
    #1;
    chk("hold_accept", 32'(req1_ready_o), 32'd1);
    step();
    drive(1, 1'b0, OP_OR, 32'hF0, 32'h0F);
    step();
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    repeat (10) begin
      #1;
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_data", rsp_data_o, 32'hFF);
      chk("hold_id", 32'(rsp_id_o), 32'd1);
      chk("hold_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
      step();
    end
    rsp_ready_i = 1;
    #1;
    chk("consume_nogrant", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
    step();
    rsp_ready_i = 0;
    chk("release_idle", 32'(rsp_valid_o), 32'd0);
    chk("release_grant", 32'(req0_ready_o), 32'd1);
    drive(0, 1'b0, OP_ADD, 32'd1, 32'd2);
    step();
    // reset in the middle of a MUL
    drive(0, 1'b1, OP_MUL, 32'd3, 32'd4);
    #1;
    chk("mul_accept", 32'(req0_ready_o), 32'd1);
    step();
    drive(0, 1'b0, OP_MUL, 32'd3, 32'd4);
    step();
    rst_i = 0;
    #1;
    chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_data", rsp_data_o, 32'd0);
    repeat (2) step();
    rst_i = 1;
    repeat (6) step();
    chk("midrst_norsp", 32'(rsp_valid_o), 32'd0);
    // both requesters continuously valid: expect 0,1,0,1 after reset
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    drive(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    rsp_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      #1;
      while (!(req0_ready_o || req1_ready_o) && w < 10) begin
        step();
        w++;
      end
      if (w >= 10) chk("arb_timeout", 32'd0, 32'd1);
      else chk("arb_grant", 32'(req1_ready_o), 32'(k % 2));
      step();
    end
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    repeat (4) step();
    rsp_ready_i = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
